// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared state encodings and defaults for the MEM stage
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mau_state_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load enable and sync reset
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [1:0]  wb_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] alu_i,
    input  logic [4:0]  writereg_i,
    output logic [1:0]  wb_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_o,
    output logic [4:0]  writereg_o
);

    logic [1:0]  wb_q;
    logic [31:0] rdata_q;
    logic [31:0] alu_q;
    logic [4:0]  writereg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q       <= '0;
            rdata_q    <= '0;
            alu_q      <= '0;
            writereg_q <= '0;
        end else if (load_i) begin
            wb_q       <= wb_i;
            rdata_q    <= rdata_i;
            alu_q      <= alu_i;
            writereg_q <= writereg_i;
        end
    end

    assign wb_o       = wb_q;
    assign rdata_o    = rdata_q;
    assign alu_o      = alu_q;
    assign writereg_o = writereg_q;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: data-memory handshake FSM, stall/branch control
module mem_access_unit
    import mips_pipe_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc_in,
    input  logic [1:0]  wb_in,
    input  logic        memwrite,
    input  logic        memread,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] alu_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  writereg_in,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        err,
    output logic        misalign,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  wb_out,
    output logic [31:0] rdata_out,
    output logic [31:0] alu_out,
    output logic [4:0]  writereg_out
);

    mau_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    misalign_q, misalign_d;

    logic        mem_op, misaligned, access, start;
    logic        mwb_load;
    logic [1:0]  mwb_wb;
    logic [31:0] mwb_rdata;

    assign mem_op     = memread | memwrite;
    assign misaligned = mem_op & (alu_in[1:0] != 2'b00);
    assign access     = mem_op & ~misaligned;
    assign start      = (state_q == ST_IDLE) & ce & access;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        misalign_d = 1'b0;
        mwb_load   = 1'b0;
        mwb_wb     = wb_in;
        mwb_rdata  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (ce) begin
                    if (access) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                        we_d    = memwrite;
                        addr_d  = alu_in;
                        wdata_d = wdata_in;
                    end else begin
                        // Misaligned ops retire as bubbles: no writeback, no memory traffic
                        mwb_load   = 1'b1;
                        misalign_d = misaligned;
                        if (misaligned) mwb_wb = 2'b00;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d   = ST_IDLE;
                    mwb_load  = 1'b1;
                    mwb_rdata = we_q ? 32'd0 : dmem_rdata;
                    we_d      = 1'b0;
                    addr_d    = '0;
                    wdata_d   = '0;
                end else if (cnt_q == WAIT_CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
        end
    end

    mem_wb_reg u_mem_wb (
        .clk        (clk),
        .rst        (rst),
        .load_i     (mwb_load),
        .wb_i       (mwb_wb),
        .rdata_i    (mwb_rdata),
        .alu_i      (alu_in),
        .writereg_i (writereg_in),
        .wb_o       (wb_out),
        .rdata_o    (rdata_out),
        .alu_o      (alu_out),
        .writereg_o (writereg_out)
    );

    assign dmem_req      = (state_q == ST_WAIT);
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign err           = (state_q == ST_ERR);
    assign misalign      = misalign_q;
    assign stall         = start | ((state_q == ST_WAIT) & ~dmem_ack) | (state_q == ST_ERR);
    assign pcsrc         = branch & zero & ce & ~stall;
    assign branch_target = pc_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, ce;
    logic [31:0] pc_in;
    logic [1:0]  wb_in;
    logic        memwrite, memread, branch, zero;
    logic [31:0] alu_in, wdata_in;
    logic [4:0]  writereg_in;
    logic        pcsrc, stall, err, misalign;
    logic [31:0] branch_target;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  wb_out;
    logic [31:0] rdata_out, alu_out;
    logic [4:0]  writereg_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ce(ce), .pc_in(pc_in), .wb_in(wb_in),
        .memwrite(memwrite), .memread(memread), .branch(branch), .zero(zero),
        .alu_in(alu_in), .wdata_in(wdata_in), .writereg_in(writereg_in),
        .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall), .err(err),
        .misalign(misalign), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_out(wb_out), .rdata_out(rdata_out),
        .alu_out(alu_out), .writereg_out(writereg_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; pc_in = '0; wb_in = '0; memwrite = 1'b0; memread = 1'b0;
        branch = 1'b0; zero = 1'b0; alu_in = '0; wdata_in = '0; writereg_in = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_wb", 32'(wb_out), 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);

        // Load with ack on the third WAIT cycle
        memread = 1'b1; alu_in = 32'h100; wb_in = 2'b11; writereg_in = 5'd5;
        #1;
        check("ld_stall_idle", 32'(stall), 32'd1);
        step();
        check("ld_req", 32'(dmem_req), 32'd1);
        check("ld_addr", dmem_addr, 32'h100);
        check("ld_we", 32'(dmem_we), 32'd0);
        check("ld_stall_w1", 32'(stall), 32'd1);
        step();
        check("ld_stall_w2", 32'(stall), 32'd1);
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_stall_ack", 32'(stall), 32'd0);
        step();
        memread = 1'b0; dmem_ack = 1'b0;
        check("ld_rdata", rdata_out, 32'hDEADBEEF);
        check("ld_wb", 32'(wb_out), 32'd3);
        check("ld_alu", alu_out, 32'h100);
        check("ld_wreg", 32'(writereg_out), 32'd5);
        check("ld_req_done", 32'(dmem_req), 32'd0);

        // Store with immediate ack
        memwrite = 1'b1; alu_in = 32'h204; wdata_in = 32'h12345678; wb_in = 2'b01;
        step();
        check("st_req", 32'(dmem_req), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_addr", dmem_addr, 32'h204);
        check("st_wdata", dmem_wdata, 32'h12345678);
        dmem_ack = 1'b1; dmem_rdata = 32'hAAAA5555;
        #1;
        check("st_stall_ack", 32'(stall), 32'd0);
        step();
        memwrite = 1'b0; dmem_ack = 1'b0;
        check("st_rdata", rdata_out, 32'd0);
        check("st_req_done", 32'(dmem_req), 32'd0);
        check("st_we_done", 32'(dmem_we), 32'd0);
        check("st_wb", 32'(wb_out), 32'd1);

        // Misaligned load
        memread = 1'b1; alu_in = 32'h102; wb_in = 2'b11;
        #1;
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_req0", 32'(dmem_req), 32'd0);
        step();
        memread = 1'b0;
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_wb", 32'(wb_out), 32'd0);
        check("mis_alu", alu_out, 32'h102);
        check("mis_req1", 32'(dmem_req), 32'd0);
        step();
        check("mis_pulse_end", 32'(misalign), 32'd0);

        // Non-memory op: latency 1
        wb_in = 2'b10; alu_in = 32'h55; writereg_in = 5'd7;
        step();
        check("nop_alu", alu_out, 32'h55);
        check("nop_wb", 32'(wb_out), 32'd2);
        check("nop_rdata", rdata_out, 32'd0);

        // ce low: no access, MEM/WB holds
        ce = 1'b0; memread = 1'b1; alu_in = 32'h77;
        #1;
        check("ce0_stall", 32'(stall), 32'd0);
        step();
        check("ce0_req", 32'(dmem_req), 32'd0);
        check("ce0_alu", alu_out, 32'h55);
        ce = 1'b1; memread = 1'b0;

        // Branch resolution
        branch = 1'b1; zero = 1'b1; pc_in = 32'h40;
        #1;
        check("br_taken", 32'(pcsrc), 32'd1);
        check("br_target", branch_target, 32'h40);
        zero = 1'b0;
        #1;
        check("br_not_taken", 32'(pcsrc), 32'd0);
        branch = 1'b0;

        // Timeout: no ack ever
        memread = 1'b1; alu_in = 32'h300;
        step();
        memread = 1'b0; alu_in = 32'h999;
        for (int i = 1; i < 15; i++) step();
        check("to_not_yet", 32'(err), 32'd0);
        check("to_req_w15", 32'(dmem_req), 32'd1);
        step();
        check("to_err", 32'(err), 32'd1);
        check("to_stall", 32'(stall), 32'd1);
        check("to_req", 32'(dmem_req), 32'd0);
        step(); step();
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_mwb_hold", alu_out, 32'h55);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("to_rst_err", 32'(err), 32'd0);
        check("to_rst_alu", alu_out, 32'd0);
        check("to_rst_wb", 32'(wb_out), 32'd0);

        // Reset mid-WAIT followed by a late ack
        memread = 1'b1; alu_in = 32'h400; wb_in = 2'b11; writereg_in = 5'd9;
        step();
        check("rw_req", 32'(dmem_req), 32'd1);
        rst = 1'b1; memread = 1'b0; wb_in = '0; alu_in = '0; writereg_in = '0;
        step();
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_ack = 1'b0;
        check("rw_req0", 32'(dmem_req), 32'd0);
        check("rw_rdata", rdata_out, 32'd0);
        check("rw_alu", alu_out, 32'd0);
        check("rw_wb", 32'(wb_out), 32'd0);
        check("rw_addr", dmem_addr, 32'd0);
        check("rw_stall", 32'(stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset; ce in 1, pipeline clock enable.
REQ-002 SHALL take EX/MEM-side inputs: pc_in in 32, branch target; wb_in in 2, [1]=memtoreg [0]=regwrite; memwrite in 1; memread in 1; branch in 1; zero in 1; alu_in in 32, address/result; wdata_in in 32, store data (rt); writereg_in in 5.
REQ-003 SHALL drive pipeline control: pcsrc out 1, branch taken; branch_target out 32; stall out 1, hold upstream; err out 1, sticky timeout; misalign out 1, one-cycle pulse.
REQ-004 SHALL drive data-memory port: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_rdata in 32; dmem_ack in 1.
REQ-005 SHALL drive MEM/WB outputs: wb_out out 2; rdata_out out 32; alu_out out 32; writereg_out out 5.
REQ-006 SHALL have parameter TIMEOUT, default 15, max WAIT cycles before error.

Function
REQ-007 access = (memread|memwrite) & ~misaligned, with misaligned = (memread|memwrite) & (alu_in[1:0]!=0).
REQ-008 FSM states: IDLE, WAIT, ERR.
REQ-009 IDLE & ce & access -> WAIT at next edge; dmem_req=1, dmem_we=memwrite, dmem_addr=alu_in, dmem_wdata=wdata_in latched at that edge, held stable through WAIT.
REQ-010 WAIT & dmem_ack -> IDLE at next edge; dmem_req=0; MEM/WB loads wb_in, alu_in, writereg_in, and rdata_out=dmem_rdata (read) or 0 (write).
REQ-011 WAIT without ack SHALL increment a 4-bit wait counter; counter reaching TIMEOUT without ack -> ERR; counter cleared on entry to WAIT.
REQ-012 ERR SHALL be terminal until rst: err=1, stall=1, dmem_req=0, MEM/WB held.
REQ-013 stall = (IDLE & ce & access) | (WAIT & ~dmem_ack) | ERR, combinational; stall=0 in ack cycle so upstream advances at same edge MEM/WB loads.
REQ-014 IDLE & ce & ~access: MEM/WB loads inputs at next edge (latency 1), rdata_out=0.
REQ-015 Misaligned access: no dmem_req; MEM/WB loads with wb_out forced 2'b00; misalign=1 for exactly the following cycle.
REQ-016 ce=0: no new access starts, MEM/WB holds in IDLE; an access already in WAIT continues and completes/loads regardless of ce.
REQ-017 pcsrc = branch & zero & ce & ~stall, combinational; branch_target = pc_in.
REQ-018 dmem_ack while not in WAIT SHALL be ignored.

Reset
REQ-019 rst SHALL win over all events, including mid-WAIT: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_out=0, rdata_out=0, alu_out=0, writereg_out=0, err=0, misalign=0.
REQ-020 A request abandoned by rst SHALL NOT load MEM/WB; a late ack after reset is ignored (REQ-018).

Structure
REQ-021 FSM state encodings and TIMEOUT default SHALL live in shared package mips_pipe_pkg.
REQ-022 MEM/WB register SHALL be a sub-module mem_wb_reg (load enable, synchronous reset); FSM and counter in top.

Verification
REQ-023 Load: memread=1, alu_in=0x100, ack on 3rd WAIT cycle, rdata=0xDEADBEEF -> stall high 3 cycles, rdata_out=0xDEADBEEF, wb_out=wb_in one edge after ack.
REQ-024 Store: memwrite=1, alu_in=0x204, wdata_in=0x12345678, immediate ack -> dmem_we=1, dmem_addr=0x204, dmem_wdata=0x12345678 for one cycle; rdata_out=0.
REQ-025 Misaligned: memread=1, alu_in=0x102 -> dmem_req never 1, misalign pulses 1 cycle, wb_out=00, stall=0.
REQ-026 Timeout: memread=1, ack never -> err=1 after 15 WAIT cycles, stall stuck 1; rst clears all to IDLE.
REQ-027 Branch: branch=1, zero=1, pc_in=0x40, no access -> pcsrc=1, branch_target=0x40; same with zero=0 -> pcsrc=0.
REQ-028 Reset mid-WAIT then ack next cycle -> MEM/WB stays 0, state IDLE, dmem_req=0.
